// File: rtl/readout_pkg.sv
// Shared definitions for the readout buffer path.
// Holds the default buffer geometry and the controller state encoding.
// The buffer and readout_ctrl both import this package, so their widths stay consistent.
package readout_pkg;

    localparam int unsigned DEF_DATBITS = 24;
    localparam int unsigned DEF_ADDBITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/readout_ctrl.sv
// readout_ctrl: sequencer for a single-port-write / async-read readout buffer.
// It fills the buffer with one event from the front-end stream, then drains that
// event in write order to the host stream. Filling and draining never overlap.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   clr_ovf               synchronous clear of the sticky overflow flag
//   in_valid/in_data/in_end/in_ready   front-end valid/ready stream (in_end marks last word)
//   buf_we/buf_waddr/buf_wdata         buffer write port (write lands in the accept cycle)
//   buf_rd/buf_raddr/buf_rdata         buffer async read port
//   out_valid/out_data/out_last/out_ready  host valid/ready stream
//   evt_words             word count of the current or most recent event
//   overflow              sticky: an event was truncated at buffer capacity
//   busy                  controller is not idle
module readout_ctrl
    import readout_pkg::*;
#(
    parameter int unsigned DATBITS = DEF_DATBITS,
    parameter int unsigned ADDBITS = DEF_ADDBITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_ovf,
    input  logic               in_valid,
    input  logic [DATBITS-1:0] in_data,
    input  logic               in_end,
    output logic               in_ready,
    output logic               buf_we,
    output logic [ADDBITS-1:0] buf_waddr,
    output logic [DATBITS-1:0] buf_wdata,
    output logic               buf_rd,
    output logic [ADDBITS-1:0] buf_raddr,
    input  logic [DATBITS-1:0] buf_rdata,
    output logic               out_valid,
    output logic [DATBITS-1:0] out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic [ADDBITS:0]   evt_words,
    output logic               overflow,
    output logic               busy
);

    // Full-buffer word count; needs the extra bit, hence ADDBITS+1 wide counters.
    localparam logic [ADDBITS:0] CAP = {1'b1, {ADDBITS{1'b0}}};
    localparam logic [ADDBITS:0] ONE = {{ADDBITS{1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [ADDBITS:0] wptr_q, wptr_d;
    logic [ADDBITS:0] rptr_q, rptr_d;
    logic [ADDBITS:0] evt_q, evt_d;
    logic [ADDBITS:0] evt_inc;
    logic             ovf_q, ovf_d;
    logic             ovf_set;

    assign evt_inc = evt_q + ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            evt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            evt_q   <= evt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        evt_d     = evt_q;
        ovf_set   = 1'b0;
        in_ready  = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = '0;
        buf_wdata = '0;
        buf_rd    = 1'b0;
        buf_raddr = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready  = 1'b1;
                buf_we    = in_valid;
                buf_wdata = in_data;
                if (in_valid) begin
                    wptr_d  = ONE;
                    evt_d   = ONE;
                    state_d = in_end ? ST_DRAIN : ST_FILL;
                end
            end
            ST_FILL: begin
                in_ready  = 1'b1;
                buf_we    = in_valid;
                buf_waddr = wptr_q[ADDBITS-1:0];
                buf_wdata = in_data;
                if (in_valid) begin
                    wptr_d = wptr_q + ONE;
                    evt_d  = evt_inc;
                    if (in_end) begin
                        state_d = ST_DRAIN;
                    end else if (evt_inc == CAP) begin
                        // Truncate: remaining words stall and begin the next event.
                        state_d = ST_DRAIN;
                        ovf_set = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                buf_rd    = 1'b1;
                buf_raddr = rptr_q[ADDBITS-1:0];
                out_valid = 1'b1;
                out_data  = buf_rdata;
                out_last  = (rptr_q == evt_q - ONE);
                if (out_ready) begin
                    rptr_d = rptr_q + ONE;
                    if (out_last) begin
                        state_d = ST_IDLE;
                        wptr_d  = '0;
                        rptr_d  = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Set wins over clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    assign evt_words = evt_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_readout_ctrl.sv
module tb_readout_ctrl;

    localparam int DW  = 24;
    localparam int AW  = 8;
    localparam int CAP = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_ovf;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_end;
    logic          in_ready;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [DW-1:0] buf_wdata;
    logic          buf_rd;
    logic [AW-1:0] buf_raddr;
    logic [DW-1:0] buf_rdata;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic [AW:0]   evt_words;
    logic          overflow;
    logic          busy;

    readout_ctrl #(.DATBITS(DW), .ADDBITS(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr_ovf   (clr_ovf),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_end    (in_end),
        .in_ready  (in_ready),
        .buf_we    (buf_we),
        .buf_waddr (buf_waddr),
        .buf_wdata (buf_wdata),
        .buf_rd    (buf_rd),
        .buf_raddr (buf_raddr),
        .buf_rdata (buf_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .evt_words (evt_words),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Buffer model: synchronous write, combinational read.
    logic [DW-1:0] mem [CAP];
    always @(posedge clk) if (buf_we) mem[buf_waddr] <= buf_wdata;
    assign buf_rdata = buf_rd ? mem[buf_raddr] : '0;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            size;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] pend[$];
    int            cnt;
    int            exp_evt;
    logic          exp_ovf;
    int            nerr;
    int            nchk;
    int            pops;
    bit            acc;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        cnt     = 0;
        exp_evt = 0;
        exp_ovf = 1'b0;
    endtask

    // One cycle: sample at negedge+1, compare, update model, advance to next negedge.
    task automatic tick();
        bit drain;
        bit ovf_set;
        #1;
        drain = (exp_q.size() != 0);
        check("out_valid", out_valid, drain);
        check("buf_rd", buf_rd, drain);
        check("in_ready", in_ready, !drain);
        check("busy_drain", busy || !drain, 1'b1);
        if (drain) check("we_in_drain", buf_we, 1'b0);
        check("evt_words", evt_words, exp_evt);
        check("overflow", overflow, exp_ovf);
        if (drain) begin
            check("out_data", out_data, exp_q[0].data);
            check("out_last", out_last, exp_q[0].last);
            if (out_ready) begin
                if (exp_q[0].last) check("evt_words_at_last", evt_words, exp_q[0].size);
                void'(exp_q.pop_front());
                pops++;
            end
        end else begin
            check("out_data_idle", out_data, 0);
            check("out_last_idle", out_last, 1'b0);
        end
        acc     = in_valid && in_ready;
        ovf_set = 1'b0;
        if (acc) begin
            cnt++;
            exp_evt = cnt;
            pend.push_back(in_data);
            if (in_end || cnt == CAP) begin
                foreach (pend[i]) exp_q.push_back('{pend[i], i == pend.size() - 1, cnt});
                ovf_set = !in_end;
                pend.delete();
                cnt = 0;
            end
        end
        if (ovf_set) exp_ovf = 1'b1;
        else if (clr_ovf) exp_ovf = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Stream n words base.. through the DUT with random stalls; clr_idx pulses clr_ovf
    // while presenting word clr_idx.
    task automatic run(int n, int base, bit end_last, int vp, int rp, int clr_idx);
        int sent  = 0;
        int guard = 0;
        while ((sent < n || exp_q.size() != 0 || pend.size() != 0) && guard < 5000) begin
            if (!in_valid && sent < n && $urandom_range(99) < vp) begin
                in_valid = 1'b1;
                in_data  = DW'(base + sent);
                in_end   = end_last && (sent == n - 1);
            end
            clr_ovf   = in_valid && (sent == clr_idx);
            out_ready = ($urandom_range(99) < rp);
            tick();
            if (acc) begin
                sent++;
                in_valid = 1'b0;
                in_end   = 1'b0;
                in_data  = '0;
            end
            guard++;
        end
        if (guard >= 5000) check("run_timeout", 1, 0);
        in_valid  = 1'b0;
        in_end    = 1'b0;
        in_data   = '0;
        clr_ovf   = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int p0;
        nerr = 0;
        nchk = 0;
        pops = 0;
        model_reset();
        rst = 1'b1; clr_ovf = 1'b0; in_valid = 1'b0; in_data = '0; in_end = 1'b0;
        out_ready = 1'b0;

        // Reset values.
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_buf_rd", buf_rd, 1'b0);
        check("rst_buf_we", buf_we, 1'b0);
        check("rst_evt_words", evt_words, 0);
        check("rst_overflow", overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 1: three-word event.
        run(3, 1, 1'b1, 100, 100, -1);
        check("t1_evt_words", evt_words, 3);
        check("t1_overflow", overflow, 1'b0);
        check("t1_busy", busy, 1'b0);

        // 2: single word with host stalled for four cycles.
        p0 = pops;
        in_valid = 1'b1; in_data = 24'hABCDEF; in_end = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; in_data = '0; in_end = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("t2_transfers", pops - p0, 1);
        check("t2_busy", busy, 1'b0);

        // 3: 300 words, capacity truncation, remainder forms the next event.
        run(300, 'h1000, 1'b1, 100, 100, -1);
        check("t3_overflow", overflow, 1'b1);
        check("t3_evt_words", evt_words, 44);

        // 4: random stalls on a 10-word event.
        p0 = pops;
        run(10, 'h2000, 1'b1, 60, 50, -1);
        check("t4_words", pops - p0, 10);

        // 5: reset while the 5th word is presented in FILL.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = DW'('h3000 + i); in_end = 1'b0;
            tick();
        end
        in_data = DW'('h3004);
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        #1;
        check("t5_in_ready", in_ready, 1'b1);
        check("t5_busy", busy, 1'b0);
        check("t5_buf_we", buf_we, 1'b0);
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_overflow", overflow, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        p0 = pops;
        run(2, 'h4000, 1'b1, 100, 100, -1);
        check("t5_words", pops - p0, 2);

        // 6: clr_ovf coincident with a new overflow set, then alone.
        run(CAP, 'h5000, 1'b0, 100, 100, CAP - 1);
        check("t6_ovf_priority", overflow, 1'b1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tick();
        check("t6_ovf_cleared", overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/readout_ctrl.md
Name: readout_ctrl

Overview:
Sequencer for the single-port-write / async-read readout buffer (DATBITS x 2**ADDBITS).
- Fills the buffer with one event's words from a front-end valid/ready stream.
- Drains the event in write order to a host-side valid/ready stream with a last marker.
- Sits between detector front-end logic and the host readout path. It is the only driver of the buffer's we/waddr/wdata/rd/raddr.

Parameters:
DATBITS, 24, data word width (matches buffer)
ADDBITS, 8, buffer address width; capacity 2**ADDBITS words

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
clr_ovf  in  1  synchronous clear of sticky overflow flag
in_valid  in  1  front-end word available
in_data  in  DATBITS  front-end word
in_end  in  1  qualifies in_data as last word of event
in_ready  out  1  controller accepts word this cycle
buf_we  out  1  buffer write enable
buf_waddr  out  ADDBITS  buffer write address
buf_wdata  out  DATBITS  buffer write data
buf_rd  out  1  buffer read enable (buffer drives hi-Z when 0)
buf_raddr  out  ADDBITS  buffer read address
buf_rdata  in  DATBITS  buffer read data (combinational from buf_raddr)
out_valid  out  1  host word available
out_data  out  DATBITS  host word
out_last  out  1  last word of event
out_ready  in  1  host accepts word
evt_words  out  ADDBITS+1  word count of current/last event
overflow  out  1  sticky: an event was truncated at buffer capacity
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1):
  - State is IDLE.
  - wptr, rptr and evt_words are 0.
  - overflow is 0.
  - All outputs are 0 except in_ready, which is 1 (IDLE accepts).
- Handshake: a transfer occurs in a cycle where valid && ready at the rising edge. Data and flags must be held while valid && !ready.
- States: IDLE, FILL, DRAIN.
- IDLE:
  - in_ready=1.
  - On in_valid: write in_data at address 0 and set wptr=1, evt_words=1.
  - If in_end, go to DRAIN; else go to FILL.
- FILL:
  - in_ready=1.
  - buf_we = in_valid, buf_waddr = wptr[ADDBITS-1:0], buf_wdata = in_data. These are combinational from the handshake, so the write lands in the same cycle.
  - On each accepted word, wptr and evt_words increment.
  - Go to DRAIN when the accepted word has in_end=1.
  - Also go to DRAIN when the accepted word brings evt_words to 2**ADDBITS (full).
  - If full is reached without in_end, set overflow=1.
  - Words beyond capacity are stalled (in_ready=0 in DRAIN), never dropped. They start the next event.
- DRAIN:
  - in_ready=0, buf_we=0.
  - buf_rd=1, buf_raddr = rptr[ADDBITS-1:0].
  - out_valid=1, out_data = buf_rdata, so the first word is presented in the first DRAIN cycle with zero added latency.
  - out_last = (rptr == evt_words-1).
  - On out_ready, rptr increments.
  - On the transfer with out_last, go to IDLE and clear wptr and rptr. evt_words holds its value until the next IDLE accept.
- buf_rd=0 outside DRAIN. out_valid, out_last and out_data are 0 outside DRAIN.
- Single-word event: evt_words=1, and out_last=1 on the first DRAIN cycle.
- Maximum event: evt_words = 2**ADDBITS, so it needs the ADDBITS+1 bit width. rptr is also ADDBITS+1 wide, with no wrap during the event.
- overflow:
  - Set has priority over clr_ovf in the same cycle.
  - Cleared only by clr_ovf or rst.
- Reset mid-event:
  - Any partial event is discarded.
  - Buffer contents are not cleared, but are unreachable afterwards.
  - Outputs return to reset values immediately (asynchronously).
- No throughput overlap: filling and draining are mutually exclusive.

Decomposition:
- Shared package readout_pkg:
  - state encoding constants: ST_IDLE, ST_FILL, ST_DRAIN (2 bits).
  - default DATBITS/ADDBITS constants used by the buffer and controller.
- Sub-modules: none required. The buffer is instantiated alongside the controller by the parent (readout_top), not inside readout_ctrl.

Test Plan:
1. Reset, then a 3-word event 0x000001, 0x000002, 0x000003 (in_end on the 3rd) with out_ready=1 -> out stream 1, 2, 3, out_last only on 3, evt_words=3, overflow=0, then busy=0.
2. Single word 0xABCDEF with in_end, out_ready low for 4 cycles -> out_valid=1, out_last=1 and data held for 4 cycles; one transfer; then IDLE.
3. Event of 300 words with ADDBITS=8 and no in_end -> DRAIN after word 256, overflow=1, evt_words=256, 256 words out in order. The remaining 44 words plus in_end form the next event (evt_words=44).
4. Random in_valid/out_ready stalls on a 10-word event -> no duplicated or missing words; buf_we never 1 in DRAIN; buf_rd never 1 outside DRAIN.
5. rst asserted on the 5th word of FILL -> in_ready=1, busy=0 and buf_we=0 immediately. A subsequent 2-word event drains exactly 2 words.
6. overflow=1 with clr_ovf pulsed in the same cycle as a new overflow set -> overflow stays 1. clr_ovf in a later cycle -> overflow=0.
